io_stream_host: RTL and testbench

- Host-side driver for the virtual platform's data I/O port (din/din_rdy/din_req in, dout/dout_rdy out).
- Buffers operand words pushed by the testbench or host into an operand FIFO and serves them to the platform on request.
- Captures every result word the platform emits into a result FIFO, which the host drains.
- Sits directly in front of the platform top level, on the platform's fast clock `clk`, not `clk_div4`.

---
 rtl/io_stream_host.sv | 196 +++++++++++++++++++
 tb/tb_io_stream_host.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/io_stream_host.sv
// io_stream_host: host-side driver for the platform data I/O port.
// Operand words go through a FIFO and are handed to the platform with a
// 4-phase din_req/din_rdy handshake. Result words are captured on each
// dout_rdy rising edge into a first-word-fall-through result FIFO.
// Optional feature: `define IO_HOST_TIMEOUT_EN aborts a handshake that stays
// in ACK for TIMEOUT_CYCLES clk cycles and sets the sticky err_timeout flag.
module io_stream_host #(
    parameter int DEPTH          = 8,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [31:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      din,
    output logic             din_rdy,
    input  logic             din_req,
    input  logic [31:0]      dout,
    input  logic             dout_rdy,
    output logic [CNT_W-1:0] sent_cnt,
    output logic [CNT_W-1:0] recv_cnt,
    output logic             starve,
    output logic             overflow,
    output logic             err_timeout
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_ACK  = 1'b1;

    // ---------------- operand FIFO ----------------
    logic [31:0]   omem_q [DEPTH];
    logic [PW-1:0] owr_q, ord_q;
    logic [CW-1:0] ocnt_q;
    logic          ofull, oempty, opush, opop;
    logic [0:0]    state_q, state_d;
    logic          tmo_hit;

    assign ofull    = (ocnt_q == CW'(DEPTH));
    assign oempty   = (ocnt_q == '0);
    assign in_ready = !ofull;
    assign opush    = in_valid && !ofull;
    assign opop     = (state_q == S_IDLE) && din_req && !oempty;

    // Operand storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (opush) omem_q[owr_q] <= in_data;
    end

    // Operand FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            owr_q  <= '0;
            ord_q  <= '0;
            ocnt_q <= '0;
        end else begin
            if (opush) owr_q <= owr_q + PW'(1);
            if (opop)  ord_q <= ord_q + PW'(1);
            case ({opush, opop})
                2'b10:   ocnt_q <= ocnt_q + CW'(1);
                2'b01:   ocnt_q <= ocnt_q - CW'(1);
                default: ocnt_q <= ocnt_q;
            endcase
        end
    end

    // ---------------- feed FSM ----------------
    logic [31:0]      din_q, din_d;
    logic             rdy_q, rdy_d;
    logic [CNT_W-1:0] sent_q, sent_d;
    logic             starve_q;

    // Next-state: pop on request in IDLE, release on req drop (or abort) in ACK.
    always_comb begin
        state_d = state_q;
        din_d   = din_q;
        rdy_d   = rdy_q;
        sent_d  = sent_q;
        case (state_q)
            S_IDLE: if (opop) begin
                din_d   = omem_q[ord_q];
                rdy_d   = 1'b1;
                state_d = S_ACK;
            end
            S_ACK: if (!din_req) begin
                rdy_d   = 1'b0;
                sent_d  = sent_q + CNT_W'(1);
                state_d = S_IDLE;
            end else if (tmo_hit) begin
                rdy_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM registers; starve flags a request that cannot be served.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            din_q    <= '0;
            rdy_q    <= 1'b0;
            sent_q   <= '0;
            starve_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            din_q    <= din_d;
            rdy_q    <= rdy_d;
            sent_q   <= sent_d;
            starve_q <= (state_q == S_IDLE) && din_req && oempty;
        end
    end

    assign din      = din_q;
    assign din_rdy  = rdy_q;
    assign sent_cnt = sent_q;
    assign starve   = starve_q;

`ifdef IO_HOST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q;
    logic          err_q;

    assign tmo_hit     = (state_q == S_ACK) && din_req && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    assign err_timeout = err_q;

    // ACK dwell counter, held at zero outside ACK so it is clear on entry.
    always_ff @(posedge clk) begin
        if (rst || state_q != S_ACK) tmo_q <= '0;
        else                         tmo_q <= tmo_q + TW'(1);
    end

    // Sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst)          err_q <= 1'b0;
        else if (tmo_hit) err_q <= 1'b1;
    end
`else
    assign tmo_hit     = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // ---------------- result capture / FIFO ----------------
    logic [31:0]      rmem_q [DEPTH];
    logic [PW-1:0]    rwr_q, rrd_q;
    logic [CW-1:0]    rcnt_q;
    logic             rprev_q, redge, rfull, rempty, rpush, rpop;
    logic [CNT_W-1:0] recv_q;
    logic             ovf_q;

    // Fullness uses the registered count, so a same-cycle pop cannot make room.
    assign redge     = dout_rdy && !rprev_q;
    assign rfull     = (rcnt_q == CW'(DEPTH));
    assign rempty    = (rcnt_q == '0);
    assign rpush     = redge && !rfull;
    assign rpop      = !rempty && out_ready;
    assign out_valid = !rempty;
    assign out_data  = rmem_q[rrd_q];
    assign recv_cnt  = recv_q;
    assign overflow  = ovf_q;

    // Result storage.
    always_ff @(posedge clk) begin
        if (rpush) rmem_q[rwr_q] <= dout;
    end

    // Edge detect, result FIFO pointers, counter and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            rprev_q <= 1'b0;
            rwr_q   <= '0;
            rrd_q   <= '0;
            rcnt_q  <= '0;
            recv_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            rprev_q <= dout_rdy;
            if (rpush) begin
                rwr_q  <= rwr_q + PW'(1);
                recv_q <= recv_q + CNT_W'(1);
            end
            if (redge && rfull) ovf_q <= 1'b1;
            if (rpop) rrd_q <= rrd_q + PW'(1);
            case ({rpush, rpop})
                2'b10:   rcnt_q <= rcnt_q + CW'(1);
                2'b01:   rcnt_q <= rcnt_q - CW'(1);
                default: rcnt_q <= rcnt_q;
            endcase
        end
    end
endmodule

// File: tb/tb_io_stream_host.sv
// tb_io_stream_host: directed vectors for io_stream_host.
module tb_io_stream_host;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] din;
    logic        din_rdy;
    logic        din_req = 1'b0;
    logic [31:0] dout = '0;
    logic        dout_rdy = 1'b0;
    logic [15:0] sent_cnt, recv_cnt;
    logic        starve, overflow, err_timeout;

    int nerr = 0;
    int nchk = 0;

    io_stream_host #(.DEPTH(8), .CNT_W(16), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .din(din), .din_rdy(din_rdy), .din_req(din_req),
        .dout(dout), .dout_rdy(dout_rdy),
        .sent_cnt(sent_cnt), .recv_cnt(recv_cnt),
        .starve(starve), .overflow(overflow), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock, ending on a negedge. A pending push is dropped once
    // the posedge it was accepted on has passed, so each word enters once.
    task automatic step();
        bit acc;
        acc = in_valid && in_ready;
        @(negedge clk);
        if (acc) in_valid = 1'b0;
    endtask

    task automatic push(input logic [31:0] w);
        in_data  = w;
        in_valid = 1'b1;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] w [9];
        int hi;

        @(negedge clk);
        do_reset();
        chk("rst_din", din, 32'h0);
        chk("rst_din_rdy", {31'b0, din_rdy}, 32'h0);
        chk("rst_sent", {16'b0, sent_cnt}, 32'h0);
        chk("rst_recv", {16'b0, recv_cnt}, 32'h0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_flags", {29'b0, starve, overflow, err_timeout}, 32'h0);

        // two operands, two 4-clk request pulses
        push(32'h3F800000);
        push(32'h40000000);
        for (int p = 0; p < 2; p++) begin
            din_req = 1'b1;
            for (int c = 0; c < 4; c++) begin
                step();
                chk("t1_rdy_hi", {31'b0, din_rdy}, 32'h1);
                chk("t1_din", din, (p == 0) ? 32'h3F800000 : 32'h40000000);
            end
            din_req = 1'b0;
            step();
            chk("t1_rdy_lo", {31'b0, din_rdy}, 32'h0);
        end
        chk("t1_sent", {16'b0, sent_cnt}, 32'd2);

        // starvation then late arrival
        din_req = 1'b1;
        repeat (10) step();
        chk("t2_starve", {31'b0, starve}, 32'h1);
        chk("t2_rdy_wait", {31'b0, din_rdy}, 32'h0);
        push(32'h12345678);
        chk("t2_rdy_landed", {31'b0, din_rdy}, 32'h0);
        step();
        chk("t2_rdy", {31'b0, din_rdy}, 32'h1);
        chk("t2_din", din, 32'h12345678);
        chk("t2_starve_clr", {31'b0, starve}, 32'h0);
        din_req = 1'b0;
        step();
        chk("t2_sent", {16'b0, sent_cnt}, 32'd3);

        // fill past capacity, then drain in order
        for (int i = 0; i < 9; i++) w[i] = 32'hA0000000 + i;
        for (int i = 0; i < 8; i++) begin
            chk("t3_in_ready", {31'b0, in_ready}, 32'h1);
            push(w[i]);
        end
        chk("t3_full", {31'b0, in_ready}, 32'h0);
        in_data  = w[8];
        in_valid = 1'b1;
        step();
        chk("t3_held_off", {30'b0, in_valid, in_ready}, 32'h2);
        for (int k = 0; k < 9; k++) begin
            din_req = 1'b1;
            step();
            chk("t3_drain_rdy", {31'b0, din_rdy}, 32'h1);
            chk("t3_drain_din", din, w[k]);
            din_req = 1'b0;
            step();
        end
        chk("t3_sent", {16'b0, sent_cnt}, 32'd12);
        chk("t3_empty_noreq", {31'b0, in_valid}, 32'h0);

        // long dout_rdy level captured once
        dout     = 32'h40C00000;
        dout_rdy = 1'b1;
        repeat (4) step();
        dout_rdy = 1'b0;
        step();
        chk("t4_valid", {31'b0, out_valid}, 32'h1);
        chk("t4_data", out_data, 32'h40C00000);
        chk("t4_recv", {16'b0, recv_cnt}, 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t4_popped", {31'b0, out_valid}, 32'h0);

        // result overflow
        do_reset();
        for (int i = 0; i < 9; i++) begin
            dout     = 32'hB0000000 + i;
            dout_rdy = 1'b1;
            step();
            dout_rdy = 1'b0;
            step();
        end
        chk("t5_overflow", {31'b0, overflow}, 32'h1);
        chk("t5_recv", {16'b0, recv_cnt}, 32'd8);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t5_valid", {31'b0, out_valid}, 32'h1);
            chk("t5_data", out_data, 32'hB0000000 + i);
            step();
        end
        out_ready = 1'b0;
        chk("t5_empty", {31'b0, out_valid}, 32'h0);
        chk("t5_ovf_sticky", {31'b0, overflow}, 32'h1);

        // request held for 100 clk
        do_reset();
        push(32'hCAFEF00D);
        din_req = 1'b1;
        hi = 0;
        repeat (100) begin
            step();
            if (din_rdy) hi++;
        end
        chk("t6_sent_held", {16'b0, sent_cnt}, 32'd0);
`ifdef IO_HOST_TIMEOUT_EN
        chk("t6_rdy_cycles", hi, 32'd64);
        chk("t6_err", {31'b0, err_timeout}, 32'h1);
`else
        chk("t6_rdy_cycles", hi, 32'd100);
        chk("t6_err", {31'b0, err_timeout}, 32'h0);
`endif
        din_req = 1'b0;
        step();
`ifdef IO_HOST_TIMEOUT_EN
        chk("t6_sent_after", {16'b0, sent_cnt}, 32'd0);
`else
        chk("t6_sent_after", {16'b0, sent_cnt}, 32'd1);
`endif
        chk("t6_rdy_lo", {31'b0, din_rdy}, 32'h0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
